// File: rtl/decode_execute_stage_if.sv
// Fetch-side bus of the decode/execute stage: instruction in, write-back and debug read out.
interface decode_execute_stage_if;
    logic [7:0] Instr_Code;
    logic       Instr_Valid;
    logic [2:0] Dbg_Sel;
    logic       Wb_En;
    logic [2:0] Wb_Addr;
    logic [7:0] Wb_Data;
    logic       Wb_Carry;
    logic       Illegal;
    logic [7:0] Retired_Cnt;
    logic [7:0] Dbg_Data;

    modport master (
        output Instr_Code, Instr_Valid, Dbg_Sel,
        input  Wb_En, Wb_Addr, Wb_Data, Wb_Carry, Illegal, Retired_Cnt, Dbg_Data
    );

    modport slave (
        input  Instr_Code, Instr_Valid, Dbg_Sel,
        output Wb_En, Wb_Addr, Wb_Data, Wb_Carry, Illegal, Retired_Cnt, Dbg_Data
    );
endinterface

// File: rtl/decode_execute_stage.sv
// Three-stage IR -> ID/EX -> write-back pipeline over an 8x8 register file,
// with EX-to-ID forwarding so back-to-back dependent instructions never stall.
module decode_execute_stage (
    input  logic                   Clk,
    input  logic                   Reset,
    decode_execute_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        OpMov = 2'b00,
        OpAdd = 2'b01,
        OpRsv = 2'b10,
        OpJmp = 2'b11
    } opcode_e;

    logic [7:0] ir_q;
    logic       ir_v_q;

    logic       ex_v_q;
    opcode_e    ex_op_q, ex_op_d;
    logic [2:0] ex_rd_q;
    logic [7:0] ex_a_q, ex_a_d;
    logic [7:0] ex_b_q, ex_b_d;

    logic [7:0] rf_q [8];

    logic [8:0] ex_sum;
    logic [7:0] ex_result;
    logic       ex_carry;
    logic       ex_writes;

    logic [2:0] id_rd, id_rs;

    logic       wb_en_q, wb_en_d;
    logic [2:0] wb_addr_q, wb_addr_d;
    logic [7:0] wb_data_q, wb_data_d;
    logic       wb_carry_q, wb_carry_d;
    logic       illegal_q, illegal_d;
    logic [7:0] cnt_q, cnt_d;

    assign id_rd = ir_q[5:3];
    assign id_rs = ir_q[2:0];

    always_comb begin
        ex_sum    = {1'b0, ex_a_q} + {1'b0, ex_b_q};
        ex_writes = ex_v_q && ((ex_op_q == OpMov) || (ex_op_q == OpAdd));
        ex_result = (ex_op_q == OpAdd) ? ex_sum[7:0] : ex_b_q;
        ex_carry  = (ex_op_q == OpAdd) && ex_sum[8];
    end

    // The EX instruction writes the regfile at the same edge ID samples it, so bypass it.
    always_comb begin
        ex_op_d = opcode_e'(ir_q[7:6]);
        ex_a_d  = (ex_writes && (ex_rd_q == id_rd)) ? ex_result : rf_q[id_rd];
        ex_b_d  = (ex_writes && (ex_rd_q == id_rs)) ? ex_result : rf_q[id_rs];
    end

    always_comb begin
        wb_en_d    = ex_writes;
        wb_carry_d = ex_v_q && ex_carry;
        illegal_d  = ex_v_q && (ex_op_q == OpRsv);
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        cnt_d      = cnt_q;
        if (ex_v_q) begin
            wb_addr_d = ex_rd_q;
            wb_data_d = ex_result;
            cnt_d     = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir_q    <= 8'd0;
            ir_v_q  <= 1'b0;
            ex_v_q  <= 1'b0;
            ex_op_q <= OpMov;
            ex_rd_q <= 3'd0;
            ex_a_q  <= 8'd0;
            ex_b_q  <= 8'd0;
        end else begin
            ir_q    <= bus.Instr_Code;
            ir_v_q  <= bus.Instr_Valid;
            ex_v_q  <= ir_v_q;
            ex_op_q <= ex_op_d;
            ex_rd_q <= id_rd;
            ex_a_q  <= ex_a_d;
            ex_b_q  <= ex_b_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 8'(i);
            end
        end else if (ex_writes) begin
            rf_q[ex_rd_q] <= ex_result;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wb_en_q    <= 1'b0;
            wb_addr_q  <= 3'd0;
            wb_data_q  <= 8'd0;
            wb_carry_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_carry_q <= wb_carry_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.Wb_En       = wb_en_q;
    assign bus.Wb_Addr     = wb_addr_q;
    assign bus.Wb_Data     = wb_data_q;
    assign bus.Wb_Carry    = wb_carry_q;
    assign bus.Illegal     = illegal_q;
    assign bus.Retired_Cnt = cnt_q;
    assign bus.Dbg_Data    = rf_q[bus.Dbg_Sel];
endmodule
